// File: rtl/irq_ctl_pkg.sv
// irq_ctl_pkg: shared constants, FSM state type and the priority-blocking helper
// for the interrupt controller.
package irq_ctl_pkg;

  localparam int N_DEF  = 32;
  localparam int VW_DEF = 5;
  // Widest request vector the blocking helper accepts.
  localparam int N_MAX  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Returns ~|rp[idx:0]. A set in-service bit at or above channel idx
  // (lower index = higher priority) blocks that channel.
  function automatic logic not_blocked(input logic [N_MAX-1:0] rp, input int idx);
    logic r;
    r = 1'b1;
    for (int j = 0; j < N_MAX; j++) begin
      if ((j <= idx) && rp[j]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctl_prio_enc.sv
// prio_enc: find-first-set over an N-bit vector. Bit 0 wins.
// Outputs a valid flag and the index of the lowest set bit.
module prio_enc
  import irq_ctl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int VW = VW_DEF
) (
  input  logic [N-1:0]  in_vec,
  output logic          valid,
  output logic [VW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = |in_vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) idx = VW'(i);
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller with a request register (rz), an in-service
// register (rp), a mask, a fixed priority chain (channel 0 highest) and a
// req/ack offer handshake to the CPU. EOI releases the most recent level.
// Build option IRQ_CTL_SYNC_EN: when defined, irq_async_ goes through a
// 2-flop synchronizer (reset to 1) before use; otherwise it is used directly.
//
// state | meaning
// IDLE  | nothing offered; latch the winner when cpu_rdy and something is eligible
// OFFER | int_vec offered with int_req=1; wait for ack, withdraw if no longer eligible
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [N-1:0]  irq_async_,
  input  logic [N-1:0]  irq_set,
  input  logic [N-1:0]  irq_clr,
  input  logic [N-1:0]  imask,
  input  logic          cpu_rdy,
  input  logic          int_ack,
  input  logic          eoi,
  output logic          int_req,
  output logic [VW-1:0] int_vec,
  output logic [N-1:0]  rz,
  output logic [N-1:0]  sz,
  output logic [N-1:0]  rp,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          int_req_q, int_req_d;
  logic [VW-1:0] int_vec_q, int_vec_d;
  logic [N-1:0]  rz_q, rz_d;
  logic [N-1:0]  rp_q, rp_d;

  logic [N-1:0]  irq_async_s;
  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [N-1:0]  eoi_clr;
  logic          cur_elig;
  logic          win_valid;
  logic [VW-1:0] win_idx;
  logic          eoi_valid;
  logic [VW-1:0] eoi_idx;

`ifdef IRQ_CTL_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for the active-low async request lines.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= irq_async_;
      sync2_q <= sync1_q;
    end
  end

  assign irq_async_s = sync2_q;
`else
  assign irq_async_s = irq_async_;
`endif

  // Masked requests and the priority chain: an in-service channel blocks
  // itself and everything of lower priority.
  always_comb begin
    sz   = rz_q & imask;
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = sz[i] & not_blocked(N_MAX'(rp_q), i);
    end
  end

  prio_enc #(.N(N), .VW(VW)) u_win (
    .in_vec (elig),
    .valid  (win_valid),
    .idx    (win_idx)
  );

  prio_enc #(.N(N), .VW(VW)) u_eoi (
    .in_vec (rp_q),
    .valid  (eoi_valid),
    .idx    (eoi_idx)
  );

  // Offer FSM next-state plus rz/rp update; ack beats withdraw, set beats clear,
  // and the EOI clear is taken from the pre-cycle rp before the grant is added.
  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    grant     = '0;
    eoi_clr   = '0;
    cur_elig  = 1'b0;

    for (int i = 0; i < N; i++) begin
      if (int_vec_q == VW'(i)) cur_elig = elig[i];
    end

    case (state_q)
      IDLE: begin
        int_req_d = 1'b0;
        if (cpu_rdy && win_valid) begin
          int_vec_d = win_idx;
          int_req_d = 1'b1;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (int_ack) begin
          for (int i = 0; i < N; i++) begin
            if (int_vec_q == VW'(i)) grant[i] = 1'b1;
          end
          int_req_d = 1'b0;
          state_d   = IDLE;
        end else if (!cur_elig) begin
          int_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        int_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (eoi && eoi_valid) begin
      for (int i = 0; i < N; i++) begin
        if (eoi_idx == VW'(i)) eoi_clr[i] = 1'b1;
      end
    end

    rz_d = (rz_q & ~(irq_clr | grant)) | (irq_set | ~irq_async_s);
    rp_d = (rp_q & ~eoi_clr) | grant;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
      rz_q      <= '0;
      rp_q      <= '0;
    end else begin
      state_q   <= state_d;
      int_req_q <= int_req_d;
      int_vec_q <= int_vec_d;
      rz_q      <= rz_d;
      rp_q      <= rp_d;
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;
  assign rz      = rz_q;
  assign rp      = rp_q;
  assign busy    = |rp_q;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed bench for irq_ctl with an expectation queue. Each step
// drives inputs, pushes the values the outputs must show after the next edge,
// then pops and compares them.
module tb_irq_ctl;

  localparam int N  = 32;
  localparam int VW = 5;
`ifdef IRQ_CTL_SYNC_EN
  localparam int ASYNC_LAT = 3;
`else
  localparam int ASYNC_LAT = 1;
`endif

  localparam int K_REQ  = 0;
  localparam int K_VEC  = 1;
  localparam int K_RZ   = 2;
  localparam int K_RP   = 3;
  localparam int K_BUSY = 4;
  localparam int K_SZ   = 5;
  localparam int K_RZ0  = 6;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_async_;
  logic [N-1:0]  irq_set;
  logic [N-1:0]  irq_clr;
  logic [N-1:0]  imask;
  logic          cpu_rdy;
  logic          int_ack;
  logic          eoi;
  logic          int_req;
  logic [VW-1:0] int_vec;
  logic [N-1:0]  rz;
  logic [N-1:0]  sz;
  logic [N-1:0]  rp;
  logic          busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  irq_ctl #(.N(N), .VW(VW)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .irq_async_ (irq_async_),
    .irq_set    (irq_set),
    .irq_clr    (irq_clr),
    .imask      (imask),
    .cpu_rdy    (cpu_rdy),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .rz         (rz),
    .sz         (sz),
    .rp         (rp),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulses_off();
    irq_set = '0;
    irq_clr = '0;
    int_ack = 1'b0;
    eoi     = 1'b0;
  endtask

  task automatic push(input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REQ:   obs = 32'(int_req);
        K_VEC:   obs = 32'(int_vec);
        K_RZ:    obs = rz;
        K_RP:    obs = rp;
        K_BUSY:  obs = 32'(busy);
        K_SZ:    obs = sz;
        K_RZ0:   obs = 32'(rz[0]);
        default: obs = 'x;
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    irq_async_ = '1;
    imask      = '1;
    cpu_rdy    = 1'b1;
    pulses_off();

    // Reset state
    tick();
    tick();
    push(K_REQ, 0, "rst_req"); push(K_VEC, 0, "rst_vec");
    push(K_RZ, 0, "rst_rz");   push(K_RP, 0, "rst_rp"); push(K_BUSY, 0, "rst_busy");
    check();
    rst = 1'b0;

    // 1: single request, accept, eoi
    irq_set[5] = 1'b1;
    push(K_RZ, 32'h20, "t1_rz"); push(K_REQ, 0, "t1_req_t1");
    tick(); pulses_off(); check();
    push(K_REQ, 1, "t1_req_t2"); push(K_VEC, 5, "t1_vec");
    tick(); check();
    int_ack = 1'b1;
    push(K_RP, 32'h20, "t1_rp"); push(K_RZ, 0, "t1_rz_clr");
    push(K_BUSY, 1, "t1_busy");  push(K_REQ, 0, "t1_req_ack");
    tick(); pulses_off(); check();
    eoi = 1'b1;
    push(K_RP, 0, "t1_rp_eoi"); push(K_BUSY, 0, "t1_busy_eoi");
    tick(); pulses_off(); check();

    // 2: simultaneous requests, lower index first, ch7 blocked until eoi
    irq_set[3] = 1'b1; irq_set[7] = 1'b1;
    push(K_RZ, 32'h88, "t2_rz");
    tick(); pulses_off(); check();
    push(K_REQ, 1, "t2_req3"); push(K_VEC, 3, "t2_vec3");
    tick(); check();
    int_ack = 1'b1;
    push(K_RP, 32'h08, "t2_rp3"); push(K_RZ, 32'h80, "t2_rz7");
    tick(); pulses_off(); check();
    tick();
    push(K_REQ, 0, "t2_blocked_a");
    tick(); check();
    eoi = 1'b1;
    push(K_RP, 0, "t2_rp_eoi"); push(K_REQ, 0, "t2_blocked_b");
    tick(); pulses_off(); check();
    push(K_REQ, 1, "t2_req7"); push(K_VEC, 7, "t2_vec7");
    tick(); check();
    int_ack = 1'b1;
    push(K_RP, 32'h80, "t2_rp7"); push(K_RZ, 0, "t2_rz_empty");
    tick(); pulses_off(); check();
    eoi = 1'b1;
    tick(); pulses_off();

    // 3: nesting under ch10
    irq_set[10] = 1'b1;
    tick(); pulses_off();
    push(K_REQ, 1, "t3_req10"); push(K_VEC, 10, "t3_vec10");
    tick(); check();
    int_ack = 1'b1;
    push(K_RP, 32'h400, "t3_rp10");
    tick(); pulses_off(); check();
    irq_set[2] = 1'b1;
    tick(); pulses_off();
    push(K_REQ, 1, "t3_req2"); push(K_VEC, 2, "t3_vec2");
    tick(); check();
    int_ack = 1'b1;
    push(K_RP, 32'h404, "t3_rp_nest");
    tick(); pulses_off(); check();
    eoi = 1'b1;
    push(K_RP, 32'h400, "t3_eoi1");
    tick(); check();
    push(K_RP, 0, "t3_eoi2"); push(K_BUSY, 0, "t3_busy");
    tick(); pulses_off(); check();

    // 4: withdraw on mask drop, re-offer after restore
    irq_set[4] = 1'b1;
    tick(); pulses_off();
    push(K_REQ, 1, "t4_req"); push(K_VEC, 4, "t4_vec");
    tick(); check();
    imask[4] = 1'b0;
    #1;
    push(K_SZ, 0, "t4_sz_masked");
    check();
    push(K_REQ, 0, "t4_withdraw"); push(K_RZ, 32'h10, "t4_rz_kept");
    tick(); check();
    imask = '1;
    push(K_REQ, 1, "t4_reoffer"); push(K_VEC, 4, "t4_revec");
    tick(); check();
    int_ack = 1'b1;
    tick(); pulses_off();
    eoi = 1'b1;
    push(K_RP, 0, "t4_rp_done"); push(K_RZ, 0, "t4_rz_done");
    tick(); pulses_off(); check();

    // 5: set over clear; set during own grant
    irq_set[1] = 1'b1; irq_clr[1] = 1'b1;
    push(K_RZ, 32'h2, "t5_set_over_clr");
    tick(); pulses_off(); check();
    push(K_REQ, 1, "t5_req1"); push(K_VEC, 1, "t5_vec1");
    tick(); check();
    int_ack = 1'b1; irq_set[1] = 1'b1;
    push(K_RZ, 32'h2, "t5_rz_regrant"); push(K_RP, 32'h2, "t5_rp1");
    tick(); pulses_off(); check();
    irq_clr[1] = 1'b1;
    push(K_REQ, 0, "t5_self_blocked"); push(K_RZ, 0, "t5_sw_clr");
    tick(); pulses_off(); check();
    eoi = 1'b1;
    push(K_RP, 0, "t5_rp_done");
    tick(); pulses_off(); check();

    // 6: reset during OFFER, then async request latency
    irq_set[6] = 1'b1;
    tick(); pulses_off();
    push(K_REQ, 1, "t6_req6");
    tick(); check();
    rst = 1'b1;
    push(K_REQ, 0, "t6_rst_req"); push(K_RZ, 0, "t6_rst_rz"); push(K_RP, 0, "t6_rst_rp");
    tick(); check();
    rst = 1'b0;
    irq_async_[0] = 1'b0;
    for (int k = 1; k <= ASYNC_LAT; k++) begin
      push(K_RZ0, (k == ASYNC_LAT) ? 32'd1 : 32'd0, "t6_async_lat");
      tick(); check();
    end
    irq_async_ = '1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Interrupt controller for the CPU interrupt system.
- Holds N request bits (rz) and N in-service bits (rp).
- Applies the interrupt mask and a fixed priority chain, and offers one vector at a time to the CPU through a req/ack handshake.
- End-of-interrupt (EOI) pulses release service levels, which allows nested interrupts.

Parameters:
N, 32, number of interrupt channels; channel 0 has the highest priority.
VW, 5, vector width; must satisfy 2**VW >= N.

Ports:
clk_sys  in  1  system clock
rst  in  1  reset; synchronous, active-high
irq_async_  in  N  asynchronous request lines, active-low level
irq_set  in  N  clocked request pulses, one per channel
irq_clr  in  N  request clear pulses (software clear)
imask  in  N  interrupt mask; 1 = enabled
cpu_rdy  in  1  CPU can accept an interrupt (between instructions)
int_ack  in  1  CPU accepts the offered vector
eoi  in  1  end-of-interrupt pulse
int_req  out  1  a vector is being offered
int_vec  out  VW  offered channel number
rz  out  N  request register
sz  out  N  rz & imask
rp  out  N  in-service register
busy  out  1  any rp bit set

Behaviour:
- Reset values: rz=0, rp=0, int_req=0, int_vec=0, FSM=IDLE. Reset overrides every other input in the same cycle.
- Request register rz, per channel, updated each clock:
  - Set source: irq_set[i] | ~irq_async_s[i], where irq_async_s is the sampled async line.
  - Clear source: irq_clr[i] | grant[i].
  - Set dominates clear. A request arriving in its own grant cycle therefore stays pending.
- sz = rz & imask. This is combinational from the registers.
- Eligibility follows the priority chain:
  - elig[i] = sz[i] & ~|rp[i:0].
  - An in-service channel blocks itself and every lower-priority channel.
  - Higher-priority channels are allowed to nest.
- Winner is the lowest-index set bit of elig.
- FSM, IDLE state:
  - int_req=0.
  - If cpu_rdy & |elig, latch the winner into int_vec and go to OFFER.
- FSM, OFFER state:
  - int_req=1. int_vec is held stable; there is no pre-emption by newly arriving higher-priority requests.
  - If int_ack, then grant[int_vec]=1: rz bit cleared (unless set in the same cycle), rp bit set. Go to IDLE.
  - Else if elig[int_vec]==0 (cleared, masked, or blocked by rp), withdraw: int_req=0 next cycle, go to IDLE.
  - Ack has priority over withdraw in the same cycle.
- Minimum re-offer gap is one IDLE cycle.
- Latency: irq_set at cycle t → rz at t+1 → IDLE latches at t+1 → int_req=1 at t+2.
- EOI:
  - eoi clears the lowest-index set bit of rp, which is the most recent nested level.
  - eoi with rp==0 is ignored.
  - eoi and a grant in the same cycle: the grant bit is set after the clear is computed, from the pre-cycle rp.
- busy = |rp.
- int_ack outside OFFER is ignored.
- cpu_rdy is sampled only in IDLE; dropping it during OFFER does not withdraw the offer.

Optional Feature:
IRQ_CTL_SYNC_EN:
- Defined: irq_async_ passes through a 2-flop synchronizer (reset to 1) before use. Async-to-rz latency is 3 cycles.
- Undefined: irq_async_ is used directly. Latency is 1 cycle, for use when sources are already synchronous to clk_sys.

Decomposition:
- irq_ctl_pkg holds:
  - default N and VW constants;
  - the state enum {IDLE, OFFER};
  - a function for the blocking mask ~|rp[i:0].
- One sub-module, prio_enc: N-bit find-first-set producing a valid flag and a VW-bit index. It is instantiated twice, once for the elig winner and once for EOI rp selection.

Test Plan:
1. Single request, set then accept: irq_set[5] pulse, imask=all ones, cpu_rdy=1 → int_req=1, int_vec=5 at t+2; int_ack → rp[5]=1, rz[5]=0, busy=1; eoi → rp=0.
2. Simultaneous requests: irq_set[3] and irq_set[7] in the same cycle → vec 3 offered first. After ack, ch7 is not offered (blocked by rp[3]). After eoi, ch7 is offered.
3. Nesting: ch10 in service, irq_set[2] → vec 2 offered and acked, rp={2,10}. First eoi clears rp[2]; second eoi clears rp[10].
4. Withdraw on mask: offering vec 4, imask[4] dropped with no ack → int_req=0 next cycle. With imask[4] restored, rz[4] is still 1 and vec 4 is re-offered.
5. Set-over-clear and set-during-grant: irq_set[1] with irq_clr[1] in the same cycle → rz[1]=1. irq_set[1] in the ack cycle of vec 1 → rz[1]=1 and rp[1]=1.
6. Reset mid-OFFER, plus async path: rst during OFFER → int_req=0 and rz=rp=0 the next cycle. irq_async_[0]=0 → rz[0] after 3 cycles with IRQ_CTL_SYNC_EN defined, 1 cycle without.
